// File: rtl/twomux_rr_arbiter.sv
// Two-requester round-robin arbiter driving the select of a 2:1 mux.
// Tenures are capped at BURST beats while the other side waits.
module twomux_rr_arbiter #(
    parameter int BURST = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             s,
    output logic             busy,
    output logic [CNT_W-1:0] beat_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic             last_b_q;
    logic             last_b_d;
    logic             s_d;
    logic [CNT_W-1:0] cnt_d;
    logic             burst_done;

    logic go_a;
    logic go_b;
    logic go_idle;
    logic restart;

    assign burst_done = (beat_cnt == BURST_C);

    // Decide which transition happens this edge.
    always_comb begin
        go_a    = 1'b0;
        go_b    = 1'b0;
        go_idle = 1'b0;
        restart = 1'b0;
        unique case (state_q)
            IDLE: begin
                unique case (1'b1)
                    req_a & ~req_b: go_a = 1'b1;
                    ~req_a & req_b: go_b = 1'b1;
                    req_a & req_b: begin
                        go_a = last_b_q;
                        go_b = ~last_b_q;
                    end
                    default: ;
                endcase
            end
            GRANT_A: begin
                unique case (1'b1)
                    ~req_a & req_b:               go_b    = 1'b1;
                    ~req_a & ~req_b:              go_idle = 1'b1;
                    req_a & req_b & burst_done:   go_b    = 1'b1;
                    req_a & ~req_b & burst_done:  restart = 1'b1;
                    default: ;
                endcase
            end
            GRANT_B: begin
                unique case (1'b1)
                    ~req_b & req_a:               go_a    = 1'b1;
                    ~req_b & ~req_a:              go_idle = 1'b1;
                    req_b & req_a & burst_done:   go_a    = 1'b1;
                    req_b & ~req_a & burst_done:  restart = 1'b1;
                    default: ;
                endcase
            end
            default: go_idle = 1'b1;
        endcase
    end

    // Apply the chosen transition to the next-state values.
    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        s_d      = s;
        cnt_d    = beat_cnt;
        if (go_a) begin
            state_d  = GRANT_A;
            last_b_d = 1'b0;
            s_d      = 1'b0;
            cnt_d    = ONE_C;
        end else if (go_b) begin
            state_d  = GRANT_B;
            last_b_d = 1'b1;
            s_d      = 1'b1;
            cnt_d    = ONE_C;
        end else if (go_idle) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (restart) begin
            cnt_d = ONE_C;
        end else if (state_q != IDLE) begin
            cnt_d = beat_cnt + ONE_C;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_b_q <= 1'b1;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            s        <= 1'b0;
            busy     <= 1'b0;
            beat_cnt <= '0;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
            gnt_a    <= (state_d == GRANT_A);
            gnt_b    <= (state_d == GRANT_B);
            s        <= s_d;
            busy     <= (state_d != IDLE);
            beat_cnt <= cnt_d;
        end
    end

endmodule

// File: doc/twomux_rr_arbiter.md
Name: twomux_rr_arbiter

Overview:
Two-requester round-robin arbiter that sits directly upstream of the 2:1 mux and drives its select line s. Source a is selected when s=0 and source b when s=1.
It grants one requester at a time, limits each tenure to BURST cycles when the other side is waiting, and alternates on ties. All outputs are registered. The mux then passes the granted source to y.

Parameters:
BURST, 4, maximum consecutive grant cycles per tenure while the other requester is waiting; legal range 1..2^CNT_W-1.
CNT_W, 3, width of the beat counter.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
req_a  input  1  source a requests the mux path.
req_b  input  1  source b requests the mux path.
gnt_a  output  1  source a currently owns the mux; registered.
gnt_b  output  1  source b currently owns the mux; registered.
s  output  1  mux select: 0 = a, 1 = b; registered; feeds the mux s input.
busy  output  1  gnt_a | gnt_b; registered.
beat_cnt  output  CNT_W  cycles granted in current tenure (1..BURST); 0 when idle.

Behaviour:
- Reset (sync, rst=1 at a rising edge):
  - state=IDLE; gnt_a=0, gnt_b=0, busy=0, s=0, beat_cnt=0.
  - last_grant=B, so a wins the first tie.
  - rst has priority over every request and over mid-tenure state. The next cycle after rst deasserts behaves as fresh IDLE.
- States: IDLE, GRANT_A, GRANT_B. At most one of gnt_a/gnt_b is ever 1 (onehot0).
- Latency: a request sampled at edge N produces a grant visible after edge N; gnt follows req by one cycle.
- IDLE:
  - req_a&~req_b -> GRANT_A.
  - ~req_a&req_b -> GRANT_B.
  - both -> grant the side opposite last_grant.
  - neither -> stay IDLE.
  - s holds its last value in IDLE (no glitch to 0); beat_cnt=0.
- On entry to GRANT_X: gnt_X=1, s=X, beat_cnt=1, last_grant=X.
- In GRANT_A (GRANT_B is symmetric). Evaluated each edge, first match wins:
  1. req_a=0 and req_b=1 -> GRANT_B directly, with no idle bubble.
  2. req_a=0 and req_b=0 -> IDLE; gnt_a=0, beat_cnt=0.
  3. req_a=1, req_b=1, beat_cnt==BURST -> GRANT_B (forced rotation).
  4. req_a=1, beat_cnt==BURST, req_b=0 -> stay GRANT_A; beat_cnt restarts at 1.
  5. otherwise stay GRANT_A; beat_cnt+1.
- A direct switch A->B updates gnt_a, gnt_b and s on the same edge; there is never a cycle with both grants high.
- The counter never exceeds BURST and never wraps.
- BURST=1: strict alternation on every cycle while both sides request.
- A request dropping mid-tenure releases the grant on the next edge regardless of beat_cnt.
- last_grant updates only on grant entry; IDLE periods do not change it.
- Fully synchronous; no latches; no combinational path from req to outputs.

Test Plan:
- Reset: rst=1 for 2 cycles with req_a=req_b=1 -> gnt_a=gnt_b=0, s=0, beat_cnt=0, busy=0. After release, the first edge gives gnt_a=1, s=0, beat_cnt=1.
- Single requester: req_b=1 only for 10 cycles -> gnt_b=1, s=1 from the edge after assertion. beat_cnt runs 1,2,3,4,1,2,... At req_b=0, gnt_b=0 next edge, s stays 1, beat_cnt=0.
- Contention, BURST=4: req_a=req_b=1 held 16 cycles from IDLE -> grants alternate a,a,a,a,b,b,b,b,a,... s toggles every 4 cycles. gnt_a&gnt_b never 1.
- Early release: in GRANT_A at beat_cnt=2, drop req_a with req_b=1 -> next edge gnt_a=0, gnt_b=1, s=1, beat_cnt=1, no IDLE cycle.
- Tie fairness: grant b once, return to IDLE for 3 cycles, then raise req_a and req_b together -> gnt_a wins.
- Reset mid-tenure: rst=1 in GRANT_B at beat_cnt=3 -> next edge all outputs at reset values. Then a tie grants a. Repeat with BURST=1 and both requesting -> s toggles every cycle.
